// File: rtl/countdown_timer_pkg.sv
// Shared timer definitions.
//   timer_state_t : FSM encoding used by the countdown timer (IDLE, RUN, DONE)
//   TIMER_WIDTH   : default counter width, shared with the up-counter instances
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

    localparam int unsigned TIMER_WIDTH = 32'd8;

endpackage : timer_pkg

// File: rtl/countdown_timer_if.sv
// Control/status bundle of the countdown timer.
//   en          : count enable (decrement only while running)
//   start       : level-sampled start/restart request
//   load_val    : terminal count, sampled when a start or reload is accepted
//   auto_reload : rerun with load_val after each expiry
//   count       : remaining count
//   busy        : high while running
//   done        : one-cycle expiry pulse
// Modports: master drives the controls, slave is the timer itself.
interface countdown_timer_if
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH = TIMER_WIDTH
);

    logic             en;
    logic             start;
    logic [WIDTH-1:0] load_val;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;

    modport master (
        output en, start, load_val, auto_reload,
        input  count, busy, done
    );

    modport slave (
        input  en, start, load_val, auto_reload,
        output count, busy, done
    );

endinterface : countdown_timer_if

// File: rtl/countdown_timer.sv
// Loadable down-counter with start/busy/done handshake.
// Loads a terminal value on start (or on auto reload after expiry), decrements
// once per enabled clock and flags expiry with a one-cycle done pulse.
// Ports:
//   clk : clock, all state updates on posedge
//   rst : asynchronous active-low reset
//   bus : countdown_timer_if.slave (en/start/load_val/auto_reload in,
//         count/busy/done out)
// busy and done are decoded only from the state register and count is a
// register, so there is no combinational input-to-output path.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH = TIMER_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    countdown_timer_if.slave        bus
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    timer_state_t     state_r;
    timer_state_t     state_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_s;
    logic             load_zero_s;

    assign load_zero_s = (bus.load_val == CNT_ZERO);

    // State and count registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            count_r <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
        end
    end

    // Next-state and next-count decode.
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    count_s = bus.load_val;
                    state_s = load_zero_s ? DONE : RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (bus.start) begin
                    // Restart wins over counting.
                    count_s = bus.load_val;
                    state_s = load_zero_s ? DONE : RUN;
                end else if (bus.en) begin
                    // count is never 0 in RUN; <=1 guards against wrap anyway.
                    if (count_r > CNT_ONE) begin
                        count_s = count_r - CNT_ONE;
                    end else begin
                        count_s = CNT_ZERO;
                        state_s = DONE;
                    end
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (bus.start || bus.auto_reload) begin
                    count_s = bus.load_val;
                    state_s = load_zero_s ? DONE : RUN;
                end else begin
                    count_s = CNT_ZERO;
                    state_s = IDLE;
                end
            end
            default: begin
                count_s = CNT_ZERO;
                state_s = IDLE;
            end
        endcase
    end

    assign bus.count = count_r;
    assign bus.busy  = (state_r == RUN);
    assign bus.done  = (state_r == DONE);

endmodule : countdown_timer
